adc_capture_ctrl: RTL and testbench
===================================

# adc_capture_ctrl

Sequencer for the ADC board interface, running in the ADC output clock domain. On a start pulse it drives the ADC configuration pins (dither, randomizer, PGA) and waits a settling interval. It then captures a burst of decimated 16-bit samples into an internal FIFO and streams them to the downstream consumer (UART framer) over a valid/ready handshake. It also counts ADC overrange events and mirrors status on the board LEDs.

## Interface
- `DEC`, 16: decimation factor, ≥1; one sample kept every DEC clocks.
- `SETTLE`, 64: settling cycles after config change, ≥1.
- `DEPTH`, 16: FIFO depth; power of 2, ≥2.
- `clkouta` in 1: sole clock (ADC CLKOUT+); all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle burst request; ignored unless idle.
- `cfg_pga`, `cfg_dith`, `cfg_rand` in 1 each: config, sampled on the accepted `start`.
- `burst_len` in 16: samples per burst, sampled on `start`; 0 means `start` is ignored.
- `data_in` in 16: ADC sample bus.
- `ofa` in 1: ADC overrange flag, aligned with `data_in`.
- `pga`, `dith`, `rand_` out 1: registered ADC config pins.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at burst completion.
- `ovf_cnt` out 8: overrange samples in the current burst; saturates at 255.
- `drop_cnt` out 8: samples lost to a full FIFO in the current burst; saturates at 255.
- `dout` out 16, `dout_valid` out 1, `dout_ready` in 1: output stream.
- `LED` out 8: `[7:5]` = last captured `data_in[15:13]`, `[4]` = `ovf_cnt` nonzero, `[3]` = `busy`, `[2:0]` = last captured `data_in[2:0]`.

## Operation
State machine: IDLE → CONFIG → SETTLE → CAPTURE → DRAIN → IDLE.

- **IDLE**
  - `start` with `burst_len` ≠ 0: latch cfg and `burst_len`, clear `ovf_cnt` and `drop_cnt`, go to CONFIG.
- **CONFIG** (1 cycle)
  - Load `pga`/`dith`/`rand_` from the latched cfg.
  - Load settle counter with SETTLE−1.
  - Go to SETTLE.
- **SETTLE**
  - Decrement the counter; at 0 go to CAPTURE.
  - Clear the decimation counter and the sample counter.
- **CAPTURE**
  - When the decimation counter is 0, the sample event fires:
    - `data_in` pushed if FIFO not full; otherwise `drop_cnt`++ (saturating).
    - `ofa`=1 → `ovf_cnt`++ (saturating), whether pushed or dropped.
    - Sample counter++ and LED sample bits updated.
  - Decimation counter wraps DEC−1 → 0.
  - After the event that makes the sample counter equal `burst_len`, go to DRAIN.
- **DRAIN**
  - When the FIFO is empty and no word is in the output register: pulse `done`, go to IDLE.
- Config pins hold their value after the burst until the next CONFIG.
- FIFO is first-word-fall-through behind a registered output.
  - `dout`/`dout_valid` change only when `dout_valid`=0 or `dout_ready`=1.
  - `dout` stable while `dout_valid`=1 and `dout_ready`=0.
  - Simultaneous push and pop when full: both take effect, no drop.
- Sample counter and length are 16 bit; `burst_len`=65535 is legal.

## Timing
- Reset values:
  - `pga`/`dith`/`rand_` = 0, `busy` = 0, `done` = 0, `ovf_cnt` = 0, `drop_cnt` = 0, `dout` = 0, `dout_valid` = 0, `LED` = 0.
  - FIFO empty, state IDLE.
- Reset mid-burst aborts immediately; FIFO contents are discarded and no `done` pulse is produced.
- `start` accepted at edge 0:
  - `busy`=1 after edge 0.
  - Config pins valid after edge 1.
  - CAPTURE entered after edge SETTLE+1.
  - First sample captured at edge SETTLE+2.
  - Later samples every DEC edges.
- Push → `dout_valid` latency is 1 cycle when the FIFO is empty.
- Throughput: one word per cycle while `dout_ready`=1.
- `done` asserts on the edge after the last word is accepted; `busy` falls in the same cycle.

## Configuration
- Macro `ADC_CAP_OVF_ABORT_EN`.
- **Defined:** a sample event with `ofa`=1 during CAPTURE ends capture immediately.
  - The offending sample is still pushed and counted.
  - Go to DRAIN; `done` pulses normally.
- **Not defined:** overrange is only counted and the burst always runs to `burst_len`.

## Test plan
- DEC=4, SETTLE=8, `burst_len`=5, `dout_ready`=1, `data_in` = cycle count → exactly 5 words with values spaced by 4; first word visible 1 cycle after edge 10; one `done` pulse.
- `dout_ready`=0, `burst_len`=20, DEPTH=16 → 16 stored (the output register does not add capacity), `drop_cnt`=4; after release the 16 words arrive in order and `done` pulses.
- `ofa`=1 on samples 2 and 3 of 10 → `ovf_cnt`=2, LED[4]=1. With `ADC_CAP_OVF_ABORT_EN`: only 2 words output, then `done`.
- `start` pulsed during CAPTURE, and `start` with `burst_len`=0 → both ignored, burst unaffected.
- `rst` asserted mid-CAPTURE → all outputs at reset values, `dout_valid`=0, no `done` pulse; a new burst then runs cleanly.
- `dout_ready` toggling every cycle with `burst_len`=8 → `dout` stable while stalled, 8 words output, none duplicated or lost.

Source files
------------

// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: config pins, settle wait, decimated burst capture into a FWFT FIFO, stream out.
// Define ADC_CAP_OVF_ABORT_EN to end capture on the first overrange sample.
module adc_capture_ctrl #(
  parameter int DEC    = 16,
  parameter int SETTLE = 64,
  parameter int DEPTH  = 16
) (
  input  logic        clkouta,
  input  logic        rst,
  input  logic        start,
  input  logic        cfg_pga,
  input  logic        cfg_dith,
  input  logic        cfg_rand,
  input  logic [15:0] burst_len,
  input  logic [15:0] data_in,
  input  logic        ofa,
  output logic        pga,
  output logic        dith,
  output logic        rand_,
  output logic        busy,
  output logic        done,
  output logic [7:0]  ovf_cnt,
  output logic [7:0]  drop_cnt,
  output logic [15:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [7:0]  LED
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (DEC > 1) ? $clog2(DEC) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_SETTLE,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     cfg_q, pins_q;
  logic [15:0]    len_q, smp_q;
  logic [SW-1:0]  settle_q;
  logic [DW-1:0]  dec_q;
  logic [7:0]     ovf_q, drop_q;
  logic [2:0]     led_hi_q, led_lo_q;
  logic           done_q;

  logic [15:0]    mem [DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  fcnt_q;
  logic [15:0]    dout_q;
  logic           dv_q;

  logic           start_ok, sample_evt, push, load_out, pop, last_smp, drained, ovf_abort;
  logic [CW-1:0]  occ;

  // The output register counts toward capacity, so "full" covers FIFO plus output word.
  assign occ        = fcnt_q + CW'(dv_q);
  assign start_ok   = (state_q == S_IDLE) && start && (burst_len != 16'd0);
  assign sample_evt = (state_q == S_CAPTURE) && (dec_q == '0);
  assign push       = sample_evt && ((occ < CW'(DEPTH)) || (dv_q && dout_ready));
  assign load_out   = !dv_q || dout_ready;
  assign pop        = load_out && (fcnt_q != '0);
  assign last_smp   = (smp_q + 16'd1) == len_q;
  assign drained    = (fcnt_q == '0) && !dv_q;

`ifdef ADC_CAP_OVF_ABORT_EN
  assign ovf_abort = ofa;
`else
  assign ovf_abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_ok) state_d = S_CONFIG;
      S_CONFIG:  state_d = S_SETTLE;
      S_SETTLE:  if (settle_q == '0) state_d = S_CAPTURE;
      S_CAPTURE: if (sample_evt && (last_smp || ovf_abort)) state_d = S_DRAIN;
      S_DRAIN:   if (drained) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clkouta or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cfg_q    <= '0;
      pins_q   <= '0;
      len_q    <= '0;
      smp_q    <= '0;
      settle_q <= '0;
      dec_q    <= '0;
      ovf_q    <= '0;
      drop_q   <= '0;
      led_hi_q <= '0;
      led_lo_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_DRAIN) && drained;
      if (start_ok) begin
        cfg_q  <= {cfg_pga, cfg_dith, cfg_rand};
        len_q  <= burst_len;
        ovf_q  <= '0;
        drop_q <= '0;
      end
      case (state_q)
        S_CONFIG: begin
          pins_q   <= cfg_q;
          settle_q <= SW'(SETTLE - 1);
        end
        S_SETTLE: begin
          if (settle_q != '0) settle_q <= settle_q - SW'(1);
          dec_q <= '0;
          smp_q <= '0;
        end
        S_CAPTURE: dec_q <= (dec_q == DW'(DEC - 1)) ? '0 : dec_q + DW'(1);
        default: ;
      endcase
      // Overrange is counted for every sample event, including dropped ones.
      if (sample_evt) begin
        smp_q    <= smp_q + 16'd1;
        led_hi_q <= data_in[15:13];
        led_lo_q <= data_in[2:0];
        if (ofa && (ovf_q != 8'hFF)) ovf_q <= ovf_q + 8'd1;
        if (!push && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clkouta) begin
    if (push) mem[wr_q] <= data_in;
  end

  always_ff @(posedge clkouta or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
      dout_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      fcnt_q <= fcnt_q + CW'(push) - CW'(pop);
      if (load_out) begin
        dv_q <= (fcnt_q != '0);
        if (fcnt_q != '0) dout_q <= mem[rd_q];
      end
    end
  end

  assign {pga, dith, rand_} = pins_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign ovf_cnt    = ovf_q;
  assign drop_cnt   = drop_q;
  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign LED        = {led_hi_q, (ovf_q != 8'd0), busy, led_lo_q};

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: table of bursts plus random bursts against a
// transaction-level model of the sequencer timing, FIFO occupancy and output stream.
module tb_adc_capture_ctrl;

  localparam int DEC    = 4;
  localparam int SETTLE = 8;
  localparam int DEPTH  = 16;
`ifdef ADC_CAP_OVF_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic        clkouta = 1'b0;
  logic        rst, start, cfg_pga, cfg_dith, cfg_rand, ofa, dout_ready;
  logic [15:0] burst_len, data_in;
  logic        pga, dith, rand_, busy, done, dout_valid;
  logic [7:0]  ovf_cnt, drop_cnt, LED;
  logic [15:0] dout;

  adc_capture_ctrl #(.DEC(DEC), .SETTLE(SETTLE), .DEPTH(DEPTH)) dut (
    .clkouta(clkouta), .rst(rst), .start(start),
    .cfg_pga(cfg_pga), .cfg_dith(cfg_dith), .cfg_rand(cfg_rand),
    .burst_len(burst_len), .data_in(data_in), .ofa(ofa),
    .pga(pga), .dith(dith), .rand_(rand_), .busy(busy), .done(done),
    .ovf_cnt(ovf_cnt), .drop_cnt(drop_cnt),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .LED(LED)
  );

  always #5 clkouta = ~clkouta;

  typedef struct {
    logic [15:0] data;
    int          pushEdge;
  } word_t;

  // readyMode: 0 always ready, 1 stalled until capture ends, 2 toggling, 3 random
  typedef struct {
    int          len;
    int          readyMode;
    logic [31:0] ofaMask;
    bit          counterData;
    bit          startMid;
    bit          useModel;
    int          expWords;
    int          expDrop;
    int          expOvf;
    bit          expLed4;
    bit          checkFirst;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;
  int edgeNo = 0;

  word_t       q[$];
  bit          mBusy, mDraining, mPresented, mDone;
  int          mT, mTaken, mPushed, mOvf, mDrop, mLen;
  logic [2:0]  mCfg, mPins, mLedHi, mLedLo;
  logic [15:0] mDout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, exp, edgeNo);
    end
  endtask

  task automatic modelReset();
    q.delete();
    mBusy = 0; mDraining = 0; mPresented = 0; mDone = 0;
    mT = 0; mTaken = 0; mPushed = 0; mOvf = 0; mDrop = 0; mLen = 0;
    mCfg = '0; mPins = '0; mLedHi = '0; mLedLo = '0; mDout = '0;
  endtask

  function automatic bit isSampleT(input int t);
    return (t >= SETTLE + 2) && (((t - SETTLE - 2) % DEC) == 0);
  endfunction

  // One clock edge of the burst rules, evaluated on the inputs held across that edge.
  task automatic modelEdge();
    int    qPre;
    bit    hs;
    word_t w;
    qPre  = q.size();
    hs    = mPresented && dout_ready;
    mDone = 0;
    if (!mBusy) begin
      if (start && burst_len != 16'd0) begin
        mBusy = 1; mT = 0; mTaken = 0; mPushed = 0; mOvf = 0; mDrop = 0;
        mLen = int'(burst_len);
        mCfg = {cfg_pga, cfg_dith, cfg_rand};
      end
    end else begin
      mT++;
      if (mT == 1) mPins = mCfg;
      if (mDraining) begin
        if (qPre == 0) begin
          mDone = 1; mBusy = 0; mDraining = 0;
        end
      end else if (isSampleT(mT)) begin
        if (qPre < DEPTH || hs) begin
          w.data = data_in; w.pushEdge = edgeNo;
          q.push_back(w);
          mPushed++;
        end else if (mDrop < 255) mDrop++;
        if (ofa && mOvf < 255) mOvf++;
        mLedHi = data_in[15:13];
        mLedLo = data_in[2:0];
        mTaken++;
        if (mTaken == mLen || (ABORT && ofa)) mDraining = 1;
      end
    end
    if (hs) begin
      q.delete(0);
      mPresented = 0;
    end
    if (!mPresented && q.size() > 0 && q[0].pushEdge < edgeNo) begin
      mPresented = 1;
      mDout = q[0].data;
    end
  endtask

  task automatic checkOutput();
    chk("busy", busy, mBusy);
    chk("done", done, mDone);
    chk("dout_valid", dout_valid, mPresented);
    if (mPresented) chk("dout", dout, mDout);
    chk("ovf_cnt", ovf_cnt, mOvf);
    chk("drop_cnt", drop_cnt, mDrop);
    chk("LED", LED, {mLedHi, (mOvf != 0), mBusy, mLedLo});
    chk("cfg pins", {pga, dith, rand_}, mPins);
  endtask

  task automatic tick();
    @(posedge clkouta);
    #1;
    edgeNo++;
    if (rst) modelReset();
    else modelEdge();
    checkOutput();
  endtask

  task automatic applyStimulus(input vec_t v);
    int nextT;
    bit nextSample;
    nextT      = mT + 1;
    nextSample = mBusy && !mDraining && isSampleT(nextT);
    data_in    = v.counterData ? 16'(edgeNo + 1) : 16'($urandom);
    if (nextSample && mTaken < 32) ofa = v.ofaMask[mTaken];
    else ofa = 1'($urandom_range(0, 1));
    case (v.readyMode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = mDraining;
      2:       dout_ready = ~dout_ready;
      default: dout_ready = 1'($urandom_range(0, 1));
    endcase
    if (v.startMid && mBusy && nextT == SETTLE + 2 + DEC) begin
      start = 1'b1;
      burst_len = 16'd3;
      {cfg_pga, cfg_dith, cfg_rand} = ~mCfg;
    end else begin
      start = 1'b0;
    end
  endtask

  task automatic runBurst(input vec_t v);
    logic [15:0] rx[$];
    int firstT;
    bit doneSeen;
    start = 1'b1;
    burst_len = 16'(v.len);
    {cfg_pga, cfg_dith, cfg_rand} = 3'($urandom_range(0, 7));
    dout_ready = (v.readyMode != 1);
    data_in = 16'($urandom);
    ofa = 1'b0;
    tick();
    start = 1'b0;
    chk("start accepted", busy, 1);
    firstT = -1;
    doneSeen = 0;
    for (int c = 0; c < 3000 && !doneSeen; c++) begin
      applyStimulus(v);
      if (dout_valid && dout_ready) rx.push_back(dout);
      tick();
      if (dout_valid && firstT < 0) firstT = mT;
      if (done) doneSeen = 1;
    end
    start = 1'b0;
    chk("burst done seen", doneSeen, 1);
    if (v.useModel) begin
      chk("words out", rx.size(), mPushed);
    end else begin
      chk("words out", rx.size(), v.expWords);
      chk("final drop_cnt", drop_cnt, v.expDrop);
      chk("final ovf_cnt", ovf_cnt, v.expOvf);
      chk("LED4", LED[4], v.expLed4);
    end
    if (v.checkFirst) chk("first valid edge", firstT, SETTLE + 3);
    if (v.counterData)
      for (int i = 1; i < rx.size(); i++) chk("word spacing", 32'(rx[i] - rx[i-1]), DEC);
    tick();
  endtask

  initial begin
    vecs[0] = '{len: 5,  readyMode: 0, ofaMask: 32'h0, counterData: 1, startMid: 0, useModel: 0,
                expWords: 5, expDrop: 0, expOvf: 0, expLed4: 0, checkFirst: 1};
    vecs[1] = '{len: 20, readyMode: 1, ofaMask: 32'h0, counterData: 0, startMid: 0, useModel: 0,
                expWords: 16, expDrop: 4, expOvf: 0, expLed4: 0, checkFirst: 0};
    vecs[2] = '{len: 10, readyMode: 0, ofaMask: 32'h6, counterData: 0, startMid: 0, useModel: 0,
                expWords: ABORT ? 2 : 10, expDrop: 0, expOvf: ABORT ? 1 : 2, expLed4: 1, checkFirst: 0};
    vecs[3] = '{len: 6,  readyMode: 0, ofaMask: 32'h0, counterData: 0, startMid: 1, useModel: 0,
                expWords: 6, expDrop: 0, expOvf: 0, expLed4: 0, checkFirst: 0};
    vecs[4] = '{len: 8,  readyMode: 2, ofaMask: 32'h0, counterData: 1, startMid: 0, useModel: 0,
                expWords: 8, expDrop: 0, expOvf: 0, expLed4: 0, checkFirst: 0};
    for (int i = 5; i < NV; i++)
      vecs[i] = '{len: int'($urandom_range(1, 24)), readyMode: 3, ofaMask: $urandom & $urandom & $urandom,
                  counterData: 0, startMid: 1'($urandom_range(0, 1)), useModel: 1,
                  expWords: 0, expDrop: 0, expOvf: 0, expLed4: 0, checkFirst: 0};

    modelReset();
    rst = 1'b1; start = 1'b0; burst_len = '0; data_in = '0; ofa = 1'b0; dout_ready = 1'b1;
    {cfg_pga, cfg_dith, cfg_rand} = 3'b000;
    tick();
    tick();
    chk("reset dout", dout, 0);
    rst = 1'b0;
    tick();

    $display("[TB] start with burst_len=0");
    start = 1'b1; burst_len = 16'd0;
    tick();
    start = 1'b0;
    chk("len0 ignored", busy, 0);
    tick();

    for (int i = 0; i < NV; i++) begin
      $display("[TB] vector %0d len=%0d readyMode=%0d", i, vecs[i].len, vecs[i].readyMode);
      runBurst(vecs[i]);
    end

    $display("[TB] reset during capture");
    start = 1'b1; burst_len = 16'd10; {cfg_pga, cfg_dith, cfg_rand} = 3'b101;
    tick();
    start = 1'b0;
    for (int c = 0; c < 200 && mT < SETTLE + 2 + 2 * DEC + 1; c++) begin
      applyStimulus(vecs[0]);
      tick();
    end
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput();
    chk("async reset dout_valid", dout_valid, 0);
    chk("async reset busy", busy, 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("no done after reset", done, 0);
    end
    runBurst(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
